line_clear_engine: RTL and testbench
====================================

LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 The module SHALL have parameter ROWS, default 20, giving the number of board rows; row 0 is the top row and row ROWS-1 is the bottom row.
REQ-002 The module SHALL have parameter COLS, default 12, giving the board width in cells.
REQ-003 The module SHALL have parameter AW, default 5, giving the row address width; AW SHALL satisfy 2^AW >= ROWS.
REQ-004 Port Clock, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port Start, input, 1 bit: request to run one clear pass; sampled only in IDLE.
REQ-007 Port RdAddr, output, AW bits: board row read address.
REQ-008 Port RdData, input, COLS bits: row contents, valid one cycle after RdAddr.
REQ-009 Port WrEn, output, 1 bit: board row write strobe.
REQ-010 Port WrAddr, output, AW bits: board row write address.
REQ-011 Port WrData, output, COLS bits: board row write data.
REQ-012 Port Busy, output, 1 bit: a pass is in progress.
REQ-013 Port Done, output, 1 bit: one-cycle pulse marking the end of a pass.
REQ-014 Port LinesCleared, output, AW bits: number of full rows removed by the last pass.

Function
REQ-015 A row SHALL be full when all COLS bits of RdData are 1, i.e. the AND reduction of the row.
REQ-016 The FSM SHALL have the states IDLE, READ, EVAL, FILL and DONE.
REQ-017 The FSM SHALL hold two registers, src and dst, each AW bits wide.
REQ-018 RdAddr SHALL always equal src.
REQ-019 IDLE with Start=1 SHALL load src=dst=ROWS-1, clear LinesCleared and move to READ.
REQ-020 IDLE with Start=0 SHALL remain in IDLE.
REQ-021 READ SHALL last one cycle and then move to EVAL.
REQ-022 In EVAL, a full row SHALL produce no write and SHALL increment LinesCleared.
REQ-023 In EVAL, a non-full row with src!=dst SHALL assert WrEn with WrAddr=dst and WrData=RdData during that cycle, then decrement dst.
REQ-024 In EVAL, a non-full row with src==dst SHALL produce no write and SHALL decrement dst.
REQ-025 EVAL SHALL move to READ with src decremented while src>0.
REQ-026 EVAL at src=0 SHALL move to FILL when LinesCleared, including this cycle's increment, is nonzero.
REQ-027 EVAL at src=0 SHALL move to DONE when LinesCleared is zero.
REQ-028 FILL SHALL write WrAddr=dst, WrData=0 once per cycle, decrementing dst, until row 0 has been written; it SHALL then move to DONE.
REQ-029 The FILL write count SHALL equal LinesCleared.
REQ-030 Busy SHALL be 1 in READ, EVAL and FILL, and 0 in IDLE and DONE.
REQ-031 DONE SHALL assert Done for exactly one cycle and then move to IDLE.
REQ-032 LinesCleared SHALL hold its value until the next accepted Start.
REQ-033 A full pass SHALL take 2*ROWS + LinesCleared busy cycles, with Done on the following cycle.
REQ-034 Start SHALL be ignored in READ, EVAL, FILL and DONE; a Start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-035 WrEn SHALL be 0 in IDLE, READ and DONE.
REQ-036 A write to dst SHALL never target a row not yet read; dst>=src SHALL hold at all times.
REQ-037 LinesCleared SHALL never wrap; its maximum value is ROWS.

Reset
REQ-038 Reset=1 SHALL, at the next edge and in any state, force IDLE with src=dst=0 and LinesCleared=0.
REQ-039 The cycle after a Reset edge SHALL have Busy=0, Done=0 and WrEn=0.
REQ-040 Reset SHALL override Start.
REQ-041 A pass aborted by Reset SHALL issue no further writes and SHALL NOT pulse Done.

Verification
REQ-042 Empty board (all rows 0x000), Start at cycle 0 -> Busy high for cycles 1-40, no WrEn, Done at cycle 41, LinesCleared=0.
REQ-043 Row 19=0xFFF, row 18=0x001, others 0 -> writes row19<=0x001 and rows 18..1<=0x000, then FILL row0<=0x000, LinesCleared=1, Done at cycle 42.
REQ-044 Rows 16-19=0xFFF, row 15=0xA5A, others 0 -> row19<=0xA5A, LinesCleared=4, four FILL writes ending at row 0, Done at cycle 45.
REQ-045 All 20 rows=0xFFF -> no EVAL writes, 20 FILL writes of 0x000 to rows 19..0, LinesCleared=20.
REQ-046 Row 10=0xFFF, Reset asserted in the EVAL cycle at src=15 -> next cycle Busy=0, WrEn=0, LinesCleared=0, no Done.
REQ-047 Start pulsed again at cycle 5 of a running pass -> ignored; the pass finishes with the same timing and only one Done.

Source files
------------

// File: rtl/line_clear_engine.sv
`default_nettype none
// ============================================================================
// Module      : line_clear_engine
// Description : Scans a row-addressed playfield from the bottom row upward,
//               drops every full row, compacts the remaining rows toward the
//               bottom and zero-fills the vacated rows at the top.
// Ports       : Clock, Reset      - clock, synchronous active-high reset
//               Start             - run one clear pass (sampled in IDLE)
//               RdAddr / RdData   - board read port, data one cycle after addr
//               WrEn/WrAddr/WrData- board write port
//               Busy, Done        - pass in progress / end-of-pass pulse
//               LinesCleared      - full rows removed by the last pass
// Revision    : 1.0 - initial release
// ============================================================================
module line_clear_engine #(
  parameter int ROWS = 20,
  parameter int COLS = 12,
  parameter int AW   = 5
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  output logic [AW-1:0]   RdAddr,
  input  logic [COLS-1:0] RdData,
  output logic            WrEn,
  output logic [AW-1:0]   WrAddr,
  output logic [COLS-1:0] WrData,
  output logic            Busy,
  output logic            Done,
  output logic [AW-1:0]   LinesCleared
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [AW-1:0] ZERO     = '0;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] lines_q, lines_d;
  logic          row_full;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [COLS-1:0] wr_data;

  assign row_full = &RdData;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    lines_d = lines_q;
    wr_en   = 1'b0;
    wr_addr = dst_q;
    wr_data = '0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          src_d   = ROW_LAST;
          dst_d   = ROW_LAST;
          lines_d = ZERO;
          state_d = S_READ;
        end
      end

      S_READ: begin
        state_d = S_EVAL;
      end

      S_EVAL: begin
        if (row_full) begin
          // Saturate rather than wrap; cannot be reached when 2^AW > ROWS.
          if (lines_q != '1) begin
            lines_d = lines_q + ONE;
          end
        end else begin
          // A kept row sitting where it already belongs needs no copy.
          if (src_q != dst_q) begin
            wr_en   = 1'b1;
            wr_data = RdData;
          end
          // dst never drops below src, so it only stops at row 0.
          if (dst_q != ZERO) begin
            dst_d = dst_q - ONE;
          end
        end

        if (src_q != ZERO) begin
          src_d   = src_q - ONE;
          state_d = S_READ;
        end else if (row_full || (lines_q != ZERO)) begin
          // lines_d is nonzero here, including this cycle's increment.
          state_d = S_FILL;
        end else begin
          state_d = S_DONE;
        end
      end

      S_FILL: begin
        // dst enters FILL at LinesCleared-1, so this issues exactly
        // LinesCleared zero writes ending at row 0.
        wr_en   = 1'b1;
        wr_data = '0;
        if (dst_q == ZERO) begin
          state_d = S_DONE;
        end else begin
          dst_d = dst_q - ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      lines_q <= lines_d;
    end
  end

  assign RdAddr       = src_q;
  assign WrEn         = wr_en;
  assign WrAddr       = wr_addr;
  assign WrData       = wr_data;
  assign Busy         = (state_q == S_READ) || (state_q == S_EVAL) || (state_q == S_FILL);
  assign Done         = (state_q == S_DONE);
  assign LinesCleared = lines_q;

endmodule
`default_nettype wire

// File: tb/tb_line_clear_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_clear_engine
// Description : Directed-vector bench for line_clear_engine with a behavioural
//               board memory (registered read, synchronous write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_clear_engine;

  localparam int ROWS = 20;
  localparam int COLS = 12;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [COLS-1:0] wr_data;
  logic            busy;
  logic            done;
  logic [AW-1:0]   lines;

  line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .Clock       (clk),
    .Reset       (rst),
    .Start       (start),
    .RdAddr      (rd_addr),
    .RdData      (rd_data),
    .WrEn        (wr_en),
    .WrAddr      (wr_addr),
    .WrData      (wr_data),
    .Busy        (busy),
    .Done        (done),
    .LinesCleared(lines)
  );

  always #5 clk = ~clk;

  // Board memory: written only from this block; loaded via init_board/load.
  logic [COLS-1:0] mem        [ROWS];
  logic [COLS-1:0] init_board [ROWS];
  logic [COLS-1:0] exp_board  [ROWS];
  logic            load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= init_board[i];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-pass observations
  int n_busy, done_cyc, n_done, n_wr, n_wr0, last_wa, n_order_bad, n_wr_post;

  task automatic load_board(input logic [COLS-1:0] fill_val);
    for (int i = 0; i < ROWS; i++) begin
      init_board[i] = fill_val;
      exp_board[i]  = '0;
    end
  endtask

  task automatic apply_board;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Cycle 0 is the cycle in which Start is first sampled high.
  task automatic run_pass(input int restart_at, input int reset_at);
    n_busy = 0; done_cyc = -1; n_done = 0; n_wr = 0; n_wr0 = 0;
    last_wa = -1; n_order_bad = 0; n_wr_post = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      rst   = (c == reset_at);
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (wr_en) begin
        n_wr++;
        if (wr_data == '0) n_wr0++;
        last_wa = int'(wr_addr);
        if (wr_addr < rd_addr) n_order_bad++;
        if (reset_at > 0 && c > reset_at) n_wr_post++;
      end
      if (c == reset_at) check_eq("abort_rdaddr", 32'(rd_addr), 32'd15);
      if (reset_at > 0 && c == reset_at + 1) begin
        check_eq("abort_busy",  32'(busy),  32'd0);
        check_eq("abort_wren",  32'(wr_en), 32'd0);
        check_eq("abort_lines", 32'(lines), 32'd0);
        check_eq("abort_done",  32'(done),  32'd0);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_pass(input string name, input int e_busy, input int e_done,
                            input int e_wr, input int e_wr0, input int e_lines);
    int nbad;
    check_eq({name, "_busy_cycles"}, n_busy, e_busy);
    check_eq({name, "_done_cycle"}, done_cyc, e_done);
    check_eq({name, "_done_count"}, n_done, 1);
    check_eq({name, "_writes"}, n_wr, e_wr);
    check_eq({name, "_zero_writes"}, n_wr0, e_wr0);
    check_eq({name, "_dst_ge_src"}, n_order_bad, 0);
    check_eq({name, "_lines_held"}, 32'(lines), e_lines);
    check_eq({name, "_idle_busy"}, 32'(busy), 32'd0);
    if (e_wr > 0) check_eq({name, "_last_wr_row"}, last_wa, 0);
    nbad = 0;
    for (int i = 0; i < ROWS; i++) if (mem[i] !== exp_board[i]) nbad++;
    check_eq({name, "_board_rows_bad"}, nbad, 0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy",   32'(busy),    32'd0);
    check_eq("rst_done",   32'(done),    32'd0);
    check_eq("rst_wren",   32'(wr_en),   32'd0);
    check_eq("rst_lines",  32'(lines),   32'd0);
    check_eq("rst_rdaddr", 32'(rd_addr), 32'd0);
    // Idle with Start low stays idle
    repeat (3) @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Empty board
    load_board(12'h000);
    apply_board();
    run_pass(-1, -1);
    check_pass("empty", 40, 41, 0, 0, 0);

    // One full bottom row, row 18 = 0x001
    load_board(12'h000);
    init_board[19] = 12'hFFF;
    init_board[18] = 12'h001;
    exp_board[19]  = 12'h001;
    apply_board();
    run_pass(-1, -1);
    check_pass("one_line", 41, 42, 20, 19, 1);

    // Four full rows, row 15 = 0xA5A
    load_board(12'h000);
    for (int i = 16; i < 20; i++) init_board[i] = 12'hFFF;
    init_board[15] = 12'hA5A;
    exp_board[19]  = 12'hA5A;
    apply_board();
    run_pass(-1, -1);
    check_pass("four_lines", 44, 45, 20, 19, 4);

    // Whole board full
    load_board(12'hFFF);
    apply_board();
    run_pass(-1, -1);
    check_pass("all_full", 60, 61, 20, 20, 20);

    // Restart request mid-pass is ignored
    load_board(12'h000);
    init_board[19] = 12'hFFF;
    init_board[18] = 12'h001;
    exp_board[19]  = 12'h001;
    apply_board();
    run_pass(5, -1);
    check_pass("restart_ignored", 41, 42, 20, 19, 1);

    // Abort by reset in the EVAL cycle at src=15 (cycle 10)
    load_board(12'h000);
    init_board[10] = 12'hFFF;
    apply_board();
    run_pass(-1, 10);
    check_eq("abort_done_count", n_done, 0);
    check_eq("abort_post_writes", n_wr_post, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
